// File: rtl/lcdc_bus_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcdc_bus_writer
// Purpose  : FIFO-buffered 8080-style 8-bit LCD write engine with panel reset
//            sequencer; drives the LCD pins directly.
// Revision : 1.0 - initial release
// ============================================================================
module lcdc_bus_writer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int WR_LOW_CYCLES   = 2,
    parameter int WR_HIGH_CYCLES  = 2,
    parameter int RST_CYCLES      = 8,
    parameter int RST_WAIT_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8:0]                    in_data,
    input  logic                          lcd_reset_req,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          lcdc_rst_n,
    output logic                          lcdc_cs_n,
    output logic                          lcdc_rs,
    output logic                          lcdc_wr_n,
    output logic [7:0]                    lcdc_d
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_A   = (RST_CYCLES > RST_WAIT_CYCLES) ? RST_CYCLES : RST_WAIT_CYCLES;
    localparam int MAX_B   = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(WR_HIGH_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_RST_WAIT   = 3'd1,
        ST_IDLE       = 3'd2,
        ST_SETUP      = 3'd3,
        ST_WR_LOW     = 3'd4,
        ST_WR_HIGH    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [8:0]       r_out;
    logic             w_empty;
    logic             w_full;
    logic             w_in_rst;
    logic             w_push;
    logic             w_pop;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_FULL);
    assign w_in_rst = (r_state == ST_RST_ASSERT) || (r_state == ST_RST_WAIT);
    // A reset request flushes the FIFO, so a concurrent push is dropped
    assign w_push   = in_valid && in_ready && !lcd_reset_req;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_pop        = 1'b0;
        case (r_state)
            ST_RST_ASSERT: begin
                if (r_cnt == RST_LAST) begin
                    w_state_next = ST_RST_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_RST_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            ST_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_state_next = ST_SETUP;
                    w_pop        = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_WR_LOW;
                w_cnt_next   = '0;
            end
            ST_WR_LOW: begin
                if (r_cnt == LOW_LAST) begin
                    w_state_next = ST_WR_HIGH;
                    w_cnt_next   = '0;
                end
            end
            ST_WR_HIGH: begin
                if (r_cnt == HIGH_LAST) begin
                    w_cnt_next = '0;
                    if (!w_empty) begin
                        w_state_next = ST_SETUP;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_RST_ASSERT;
                w_cnt_next   = '0;
            end
        endcase
        if (lcd_reset_req) begin
            w_state_next = ST_RST_ASSERT;
            w_cnt_next   = '0;
            w_pop        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RST_ASSERT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (lcd_reset_req) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    // Pin data/rs only move when a byte enters SETUP, keeping them stable through the strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (lcd_reset_req) begin
            r_out <= '0;
        end else if (w_pop) begin
            r_out <= r_mem[r_rd_ptr];
        end
    end

    assign in_ready   = !w_in_rst && !w_full;
    assign busy       = !((r_state == ST_IDLE) && w_empty);
    assign fifo_level = r_level;
    assign lcdc_rst_n = (r_state != ST_RST_ASSERT);
    assign lcdc_cs_n  = !((r_state == ST_SETUP) || (r_state == ST_WR_LOW) || (r_state == ST_WR_HIGH));
    assign lcdc_wr_n  = (r_state != ST_WR_LOW);
    assign lcdc_rs    = r_out[8];
    assign lcdc_d     = r_out[7:0];

endmodule
`default_nettype wire

// File: tb/tb_lcdc_bus_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcdc_bus_writer
// Purpose  : Directed self-checking bench for lcdc_bus_writer (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcdc_bus_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       lcd_reset_req;
    logic       busy;
    logic [3:0] fifo_level;
    logic       lcdc_rst_n;
    logic       lcdc_cs_n;
    logic       lcdc_rs;
    logic       lcdc_wr_n;
    logic [7:0] lcdc_d;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] cap_q [$];
    time        cap_t [$];

    lcdc_bus_writer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .lcd_reset_req (lcd_reset_req),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .lcdc_rst_n    (lcdc_rst_n),
        .lcdc_cs_n     (lcdc_cs_n),
        .lcdc_rs       (lcdc_rs),
        .lcdc_wr_n     (lcdc_wr_n),
        .lcdc_d        (lcdc_d)
    );

    always #5 clk = ~clk;

    // Panel model: record the byte presented at the start of every strobe
    always @(negedge lcdc_wr_n) begin
        cap_q.push_back({lcdc_rs, lcdc_d});
        cap_t.push_back($time);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; lcd_reset_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({lcdc_rst_n, lcdc_cs_n, lcdc_wr_n, lcdc_rs, lcdc_d} !== 12'b0110_0000_0000) begin
            n_fail++;
            $display("FAIL reset_pins: got rst_n=%b cs_n=%b wr_n=%b rs=%b d=%h, want 0 1 1 0 00",
                     lcdc_rst_n, lcdc_cs_n, lcdc_wr_n, lcdc_rs, lcdc_d);
        end
        n_checks++;
        if ({in_ready, busy, fifo_level} !== 6'b01_0000) begin
            n_fail++;
            $display("FAIL reset_status: got ready=%b busy=%b level=%0d, want 0 1 0", in_ready, busy, fifo_level);
        end
        reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (lcdc_rst_n !== (i >= 8)) begin
                n_fail++;
                $display("FAIL rst_seq_rst_n[%0d]: got %b want %b", i, lcdc_rst_n, (i >= 8));
            end
            n_checks++;
            if (in_ready !== (i >= 12) || busy !== (i < 12)) begin
                n_fail++;
                $display("FAIL rst_seq_ready_busy[%0d]: got ready=%b busy=%b want %b %b",
                         i, in_ready, busy, (i >= 12), (i < 12));
            end
            n_checks++;
            if (lcdc_cs_n !== 1'b1 || lcdc_wr_n !== 1'b1 || fifo_level !== 4'd0) begin
                n_fail++;
                $display("FAIL rst_seq_idle_pins[%0d]: got cs_n=%b wr_n=%b level=%0d want 1 1 0",
                         i, lcdc_cs_n, lcdc_wr_n, fifo_level);
            end
        end
    endtask

    task automatic test_single;
        cap_q.delete(); cap_t.delete();
        in_valid = 1'b1; in_data = 9'h12B;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd1 || lcdc_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL single_e0: got level=%0d cs_n=%b want 1 1", fifo_level, lcdc_cs_n);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (lcdc_cs_n !== (i > 5) || lcdc_wr_n !== !(i == 2 || i == 3)) begin
                n_fail++;
                $display("FAIL single_strobe[E%0d]: got cs_n=%b wr_n=%b want %b %b",
                         i, lcdc_cs_n, lcdc_wr_n, (i > 5), !(i == 2 || i == 3));
            end
            if (i <= 5) begin
                n_checks++;
                if ({lcdc_rs, lcdc_d} !== 9'h12B) begin
                    n_fail++;
                    $display("FAIL single_data[E%0d]: got %h want 12b", i, {lcdc_rs, lcdc_d});
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0 || fifo_level !== 4'd0 || cap_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b level=%0d strobes=%0d want 0 0 1", busy, fifo_level, cap_q.size());
        end else begin
            n_checks++;
            if (cap_q[0] !== 9'h12B) begin
                n_fail++;
                $display("FAIL single_panel: got %h want 12b", cap_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int  idx;
        int  gap;
        bit  seen_full;
        bit  acc;
        cap_q.delete(); cap_t.delete();
        idx = 0; gap = 0; seen_full = 0;
        for (int c = 0; c < 100 && idx < 12; c++) begin
            in_valid = 1'b1; in_data = 9'(idx);
            acc = in_ready;
            if (c >= 2 && lcdc_cs_n !== 1'b0) gap++;
            if (!acc) begin
                seen_full = 1;
                n_checks++;
                if (fifo_level !== 4'd8) begin
                    n_fail++;
                    $display("FAIL b2b_stall_level: got ready=0 at level=%0d want level 8", fifo_level);
                end
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx != 12 || !seen_full) begin
            n_fail++;
            $display("FAIL b2b_push: got pushed=%0d saw_full=%0d want 12 1", idx, seen_full);
        end
        for (int c = 0; c < 120 && busy; c++) begin
            if (lcdc_cs_n !== 1'b0) gap++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || gap != 0 || cap_q.size() != 12) begin
            n_fail++;
            $display("FAIL b2b_drain: got busy=%b cs_gaps=%0d strobes=%0d want 0 0 12", busy, gap, cap_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (cap_q[i] !== 9'(i)) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, cap_q[i], 9'(i));
                end
                if (i > 0) begin
                    n_checks++;
                    if (cap_t[i] - cap_t[i-1] != 50) begin
                        n_fail++;
                        $display("FAIL b2b_period[%0d]: got %0t want 50", i, cap_t[i] - cap_t[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap;
        int idx;
        bit acc;
        cap_q.delete(); cap_t.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = {1'(i), 8'(i * 37 + 5)};
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 4'd3) begin
            n_fail++;
            $display("FAIL wrap_level_e3: got %0d want 3", fifo_level);
        end
        tick();
        tick();
        n_checks++;
        if (fifo_level !== 4'd3) begin
            n_fail++;
            $display("FAIL wrap_level_e5: got %0d want 3", fifo_level);
        end
        in_valid = 1'b1; in_data = {1'(4), 8'(4 * 37 + 5)};
        tick();
        n_checks++;
        if (fifo_level !== 4'd3 || lcdc_cs_n !== 1'b0 || lcdc_wr_n !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_push_pop: got level=%0d cs_n=%b wr_n=%b want 3 0 1", fifo_level, lcdc_cs_n, lcdc_wr_n);
        end
        in_data = {1'(5), 8'(5 * 37 + 5)};
        tick();
        n_checks++;
        if (fifo_level !== 4'd4) begin
            n_fail++;
            $display("FAIL wrap_push_only: got %0d want 4", fifo_level);
        end
        idx = 6;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            in_data = {1'(idx), 8'(idx * 37 + 5)};
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 150 && busy; c++) tick();
        n_checks++;
        if (busy !== 1'b0 || cap_q.size() != 20) begin
            n_fail++;
            $display("FAIL wrap_drain: got busy=%b strobes=%0d want 0 20", busy, cap_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_checks++;
                if (cap_q[i] !== {1'(i), 8'(i * 37 + 5)}) begin
                    n_fail++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", i, cap_q[i], {1'(i), 8'(i * 37 + 5)});
                end
            end
        end
    endtask

    task automatic test_reset_req;
        cap_q.delete(); cap_t.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 9'h080 + 9'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (lcdc_wr_n !== 1'b0 || fifo_level !== 4'd4) begin
            n_fail++;
            $display("FAIL req_pre: got wr_n=%b level=%0d want 0 4", lcdc_wr_n, fifo_level);
        end
        lcd_reset_req = 1'b1; in_valid = 1'b1; in_data = 9'h1EE;
        tick();
        lcd_reset_req = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({lcdc_wr_n, lcdc_cs_n, lcdc_rst_n, in_ready} !== 4'b1100 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL req_next_edge: got wr_n=%b cs_n=%b rst_n=%b ready=%b level=%0d want 1 1 0 0 0",
                     lcdc_wr_n, lcdc_cs_n, lcdc_rst_n, in_ready, fifo_level);
        end
        for (int i = 1; i < 13; i++) begin
            tick();
            n_checks++;
            if (lcdc_rst_n !== (i >= 8) || in_ready !== (i >= 12) || lcdc_cs_n !== 1'b1) begin
                n_fail++;
                $display("FAIL req_seq[%0d]: got rst_n=%b ready=%b cs_n=%b want %b %b 1",
                         i, lcdc_rst_n, in_ready, lcdc_cs_n, (i >= 8), (i >= 12));
            end
        end
        repeat (10) tick();
        n_checks++;
        if (cap_q.size() != 2 || busy !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL req_after: got strobes=%0d busy=%b level=%0d want 2 0 0", cap_q.size(), busy, fifo_level);
        end else begin
            n_checks++;
            if (cap_q[0] !== 9'h080 || cap_q[1] !== 9'h081) begin
                n_fail++;
                $display("FAIL req_panel: got %h %h want 080 081", cap_q[0], cap_q[1]);
            end
        end
    endtask

    task automatic test_async_reset;
        cap_q.delete(); cap_t.delete();
        in_valid = 1'b1; in_data = 9'h155;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (lcdc_wr_n !== 1'b0 || lcdc_cs_n !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pre: got wr_n=%b cs_n=%b want 0 0", lcdc_wr_n, lcdc_cs_n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({lcdc_wr_n, lcdc_cs_n, lcdc_rst_n} !== 3'b110 || lcdc_d !== 8'h00 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL async_immediate: got wr_n=%b cs_n=%b rst_n=%b d=%h level=%0d want 1 1 0 00 0",
                     lcdc_wr_n, lcdc_cs_n, lcdc_rst_n, lcdc_d, fifo_level);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 40 && busy; c++) tick();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || cap_q.size() != 1) begin
            n_fail++;
            $display("FAIL async_recover: got busy=%b ready=%b strobes=%0d want 0 1 1", busy, in_ready, cap_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_reset_req();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
